data_mem_responder: RTL and testbench

- Data-side memory responder for the single-cycle core.
- Receives the core's data-bus outputs (alu_out as address, write_data, mem_write) and returns read_data combinationally in the same cycle, as a single-cycle datapath requires.
- Holds word-addressed data RAM plus a small MMIO region: console TX FIFO with valid/ready drain, free-running cycle counter, and compare/timer-hit interrupt.

---
 rtl/data_mem_pkg.sv | 49 ++++
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder_sync_fifo.sv | 64 ++++++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants for the data-side memory responder: MMIO map, status bit positions, reset values.
package data_mem_pkg;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] MMIO_BASE = 16'hFFFF;

  localparam logic [7:0] OFF_CON_DATA = 8'h00;
  localparam logic [7:0] OFF_CON_STAT = 8'h04;
  localparam logic [7:0] OFF_CYCLE    = 8'h08;
  localparam logic [7:0] OFF_COMPARE  = 8'h0C;
  localparam logic [7:0] OFF_TSTAT    = 8'h10;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int TSTAT_HIT_BIT  = 0;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_MMIO
  } region_e;

  typedef enum logic [2:0] {
    MMIO_CON_DATA,
    MMIO_CON_STAT,
    MMIO_CYCLE,
    MMIO_COMPARE,
    MMIO_TSTAT,
    MMIO_NONE
  } mmio_reg_e;

  // Byte lane bits are ignored, so offsets are matched on word granularity.
  function automatic mmio_reg_e mmio_decode(input logic [7:0] off);
    mmio_reg_e r;
    case ({off[7:2], 2'b00})
      OFF_CON_DATA: r = MMIO_CON_DATA;
      OFF_CON_STAT: r = MMIO_CON_STAT;
      OFF_CYCLE:    r = MMIO_CYCLE;
      OFF_COMPARE:  r = MMIO_COMPARE;
      OFF_TSTAT:    r = MMIO_TSTAT;
      default:      r = MMIO_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-bus and console/irq signals of the data memory responder.
// master = core side (drives address/store, console ready); slave = responder.
interface data_mem_responder_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output mem_write, addr, write_data, tx_ready,
    input  read_data, tx_valid, tx_data, timer_irq
  );

  modport slave (
    input  mem_write, addr, write_data, tx_ready,
    output read_data, tx_valid, tx_data, timer_irq
  );
endinterface

// File: rtl/data_mem_responder_sync_fifo.sv
// Generic synchronous FIFO: registered push, head visible the cycle after a push into empty.
// Push is accepted when not full or when a pop happens in the same cycle; pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM + MMIO (console FIFO, cycle counter, compare/timer irq).
// Loads are combinational (zero latency); console drains on tx_valid/tx_ready, overflowing bytes are dropped.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  region_e       region;
  mmio_reg_e     mreg;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_hit_q, timer_hit_d;
  logic        ovf_q, ovf_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count_unused;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[1:0];
  assign ram_idx = bus.addr[AW+1:2];

  // Addresses above RAM_WORDS in the low 64 KiB are holes, not aliases.
  always_comb begin
    region = REGION_NONE;
    if (bus.addr[31:16] == MMIO_BASE) begin
      region = REGION_MMIO;
    end else if (bus.addr[31:16] == RAM_BASE && (bus.addr[15:0] >> (AW + 2)) == 16'd0) begin
      region = REGION_RAM;
    end
  end

  assign mreg = (region == REGION_MMIO) ? mmio_decode(bus.addr[7:0]) : MMIO_NONE;

  // RAM is deliberately outside reset: a store coinciding with rst still lands.
  always_ff @(posedge clk) begin
    if (bus.mem_write && region == REGION_RAM) ram_q[ram_idx] <= bus.write_data;
  end

  assign fifo_pop  = !fifo_empty && bus.tx_ready;
  assign fifo_push = bus.mem_write && (mreg == MMIO_CON_DATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (bus.write_data[7:0]),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  // Sticky set conditions are applied last so they win over software clears.
  always_comb begin
    cycle_d     = cycle_q + 32'd1;
    compare_d   = compare_q;
    ovf_d       = ovf_q;
    timer_hit_d = timer_hit_q;
    if (bus.mem_write) begin
      case (mreg)
        MMIO_CYCLE:    cycle_d = bus.write_data;
        MMIO_COMPARE:  compare_d = bus.write_data;
        MMIO_CON_STAT: if (bus.write_data[STAT_OVF_BIT]) ovf_d = 1'b0;
        MMIO_TSTAT:    if (bus.write_data[TSTAT_HIT_BIT]) timer_hit_d = 1'b0;
        default:       ;
      endcase
    end
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (cycle_q == compare_q) timer_hit_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      compare_q   <= COMPARE_RST;
      timer_hit_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      compare_q   <= compare_d;
      timer_hit_q <= timer_hit_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    bus.read_data = 32'h0;
    if (region == REGION_RAM) begin
      bus.read_data = ram_q[ram_idx];
    end else begin
      case (mreg)
        MMIO_CON_STAT: begin
          bus.read_data[STAT_EMPTY_BIT] = fifo_empty;
          bus.read_data[STAT_FULL_BIT]  = fifo_full;
          bus.read_data[STAT_OVF_BIT]   = ovf_q;
        end
        MMIO_CYCLE:   bus.read_data = cycle_q;
        MMIO_COMPARE: bus.read_data = compare_q;
        MMIO_TSTAT:   bus.read_data[TSTAT_HIT_BIT] = timer_hit_q;
        default:      bus.read_data = 32'h0;
      endcase
    end
  end

  assign bus.tx_valid  = !fifo_empty;
  assign bus.tx_data   = fifo_empty ? 8'h00 : fifo_head;
  assign bus.timer_irq = timer_hit_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed stores/loads, console drain, counter and timer.
module tb_data_mem_responder;

  localparam logic [31:0] A_CON  = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_TST  = 32'hFFFF_0010;

  localparam int S_RD  = 0;
  localparam int S_VLD = 1;
  localparam int S_DAT = 2;
  localparam int S_IRQ = 3;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       q[$];
  logic [7:0] txq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.mem_write  = we;
    bus.addr       = a;
    bus.write_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_chk(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask

  // Monitor: compares queued expectations mid-cycle and every console handshake.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  b;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        S_RD:    act = bus.read_data;
        S_VLD:   act = {31'b0, bus.tx_valid};
        S_DAT:   act = {24'b0, bus.tx_data};
        default: act = {31'b0, bus.timer_irq};
      endcase
      check(e.name, act, e.val);
    end
    if (bus.tx_valid && bus.tx_ready) begin
      if (txq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %02h, expected no handshake", bus.tx_data);
      end else begin
        b = txq.pop_front();
        check("tx_drain", {24'b0, bus.tx_data}, {24'b0, b});
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    drive(0, A_CYC, 0);
    tick();

    // Reset state
    exp_chk(S_RD, 32'h0, "rst_cycle");
    exp_chk(S_VLD, 32'h0, "rst_tx_valid");
    exp_chk(S_DAT, 32'h0, "rst_tx_data");
    exp_chk(S_IRQ, 32'h0, "rst_irq");
    tick();
    drive(0, A_STAT, 0); exp_chk(S_RD, 32'h1, "rst_con_stat"); tick();
    drive(0, A_CMP, 0);  exp_chk(S_RD, 32'hFFFF_FFFF, "rst_compare"); tick();
    drive(0, A_TST, 0);  exp_chk(S_RD, 32'h0, "rst_tstat"); tick();

    // Free-running counter after reset release
    rst = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      drive(0, A_CYC, 0);
      exp_chk(S_RD, i, "cycle_count");
      tick();
    end
    drive(1, A_CYC, 32'hFFFF_FFFE); exp_chk(S_RD, 32'd6, "cycle_before_load"); tick();
    drive(0, A_CYC, 0);
    exp_chk(S_RD, 32'hFFFF_FFFE, "cycle_loaded"); exp_chk(S_IRQ, 0, "irq_pre_wrap"); tick();
    exp_chk(S_RD, 32'hFFFF_FFFF, "cycle_max"); exp_chk(S_IRQ, 0, "irq_at_max"); tick();
    // Counter matched the reset compare value on the previous cycle
    exp_chk(S_RD, 32'h0, "cycle_wrap"); exp_chk(S_IRQ, 1, "irq_after_max_match"); tick();
    drive(1, A_TST, 32'h1); exp_chk(S_RD, 32'h1, "tstat_set"); tick();
    drive(0, A_TST, 0); exp_chk(S_RD, 32'h0, "tstat_cleared"); exp_chk(S_IRQ, 0, "irq_cleared"); tick();

    // Timer hit at compare = 20
    drive(1, A_CMP, 32'd20); tick();
    drive(1, A_CYC, 32'd0); tick();
    for (int i = 0; i <= 21; i++) begin
      drive(0, A_CYC, 0);
      exp_chk(S_RD, i, "timer_cycle");
      exp_chk(S_IRQ, (i == 21) ? 32'h1 : 32'h0, "timer_irq_edge");
      tick();
    end
    drive(0, A_TST, 0); exp_chk(S_RD, 32'h1, "tstat_hit"); exp_chk(S_IRQ, 1, "irq_sticky"); tick();
    drive(1, A_TST, 32'h1); tick();
    drive(1, A_CYC, 32'd18); exp_chk(S_IRQ, 0, "irq_clear2"); tick();
    drive(0, A_CYC, 0); exp_chk(S_RD, 32'd18, "cyc18"); tick();
    exp_chk(S_RD, 32'd19, "cyc19"); tick();
    drive(1, A_TST, 32'h1); exp_chk(S_RD, 32'h0, "tstat_before_match"); tick();
    drive(0, A_TST, 0); exp_chk(S_RD, 32'h1, "set_beats_clear"); exp_chk(S_IRQ, 1, "irq_set_beats_clear"); tick();

    // Console: three bytes, then drain
    drive(1, A_CON, 32'h41); exp_chk(S_VLD, 0, "no_bypass"); tick();
    drive(1, A_CON, 32'h42); exp_chk(S_VLD, 1, "tx_valid_1"); exp_chk(S_DAT, 32'h41, "tx_head_1"); tick();
    drive(1, A_CON, 32'h43); tick();
    drive(0, A_STAT, 0);
    exp_chk(S_RD, 32'h0, "stat_partial"); exp_chk(S_VLD, 1, "tx_valid_3"); exp_chk(S_DAT, 32'h41, "tx_head_3");
    txq.push_back(8'h41); txq.push_back(8'h42); txq.push_back(8'h43);
    tick();
    bus.tx_ready = 1'b1;
    repeat (3) tick();
    bus.tx_ready = 1'b0;
    exp_chk(S_RD, 32'h1, "stat_drained"); exp_chk(S_VLD, 0, "tx_valid_drained"); exp_chk(S_DAT, 0, "tx_data_empty");
    exp_chk(S_RD, 32'h1, "con_data_read");
    tick();
    drive(0, A_CON, 0); exp_chk(S_RD, 32'h0, "con_data_reads_zero"); tick();

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) begin
      drive(1, A_CON, 32'h50 + i);
      if (i < 8) txq.push_back(8'(8'h50 + i));
      tick();
    end
    drive(0, A_STAT, 0); exp_chk(S_RD, 32'h6, "stat_overflow"); tick();
    drive(1, A_STAT, 32'h4); tick();
    drive(0, A_STAT, 0); exp_chk(S_RD, 32'h2, "stat_ovf_cleared"); tick();
    drive(1, A_CON, 32'h60); bus.tx_ready = 1'b1; txq.push_back(8'h60); tick();
    bus.tx_ready = 1'b0;
    drive(0, A_STAT, 0); exp_chk(S_RD, 32'h2, "stat_push_pop_full"); tick();
    bus.tx_ready = 1'b1;
    repeat (8) tick();
    bus.tx_ready = 1'b0;
    exp_chk(S_RD, 32'h1, "stat_empty_again"); tick();

    // RAM and unmapped space
    drive(1, 32'h0000_0000, 32'h1111_1111); tick();
    drive(1, 32'h0000_0010, 32'hDEAD_BEEF); tick();
    drive(0, 32'h0000_0010, 0); exp_chk(S_RD, 32'hDEAD_BEEF, "ram_read"); tick();
    drive(0, 32'h0000_0013, 0); exp_chk(S_RD, 32'hDEAD_BEEF, "ram_byte_bits_ignored"); tick();
    drive(0, 32'h0000_1000, 0); exp_chk(S_RD, 32'h0, "unmapped_1000"); tick();
    drive(1, 32'h0000_0100, 32'hAAAA_AAAA); tick();
    drive(0, 32'h0000_0100, 0); exp_chk(S_RD, 32'h0, "ram_hole_read"); tick();
    drive(0, 32'h0000_0000, 0); exp_chk(S_RD, 32'h1111_1111, "ram_no_alias"); tick();
    drive(0, 32'hFFFF_0014, 0); exp_chk(S_RD, 32'h0, "mmio_unmapped"); tick();
    drive(0, A_CMP, 0); exp_chk(S_RD, 32'd20, "compare_read"); tick();

    // Reset mid-operation: four queued bytes, timer_hit set
    for (int i = 0; i < 4; i++) begin
      drive(1, A_CON, 32'h70 + i);
      tick();
    end
    drive(0, A_STAT, 0);
    exp_chk(S_RD, 32'h0, "stat_pre_rst"); exp_chk(S_IRQ, 1, "irq_pre_rst"); exp_chk(S_VLD, 1, "tx_valid_pre_rst");
    tick();
    rst = 1'b1;
    drive(1, 32'h0000_0014, 32'h1234_5678);
    tick();
    rst = 1'b0;
    drive(0, A_CYC, 0);
    exp_chk(S_RD, 32'h0, "cycle_after_rst"); exp_chk(S_VLD, 0, "tx_valid_after_rst");
    exp_chk(S_IRQ, 0, "irq_after_rst"); exp_chk(S_DAT, 0, "tx_data_after_rst");
    tick();
    drive(0, 32'h0000_0014, 0); exp_chk(S_RD, 32'h1234_5678, "ram_write_during_rst"); tick();
    rst = 1'b1;
    drive(1, A_CMP, 32'd5);
    tick();
    rst = 1'b0;
    drive(0, A_CMP, 0); exp_chk(S_RD, 32'hFFFF_FFFF, "mmio_store_ignored_in_rst"); tick();
    tick();

    check("txq_all_drained", txq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
